// File: rtl/uart_mmio_periph.sv
// uart_mmio_periph: memory-mapped 8N1 UART responder on the CPU data bus.
// Three word registers at BASE_ADDR: TXD (+0), RXD (+4), CON (+8).
// Optional feature macro: UART_PARITY_EN (frame becomes 8E1 with an even-parity bit).
// Bus handshake: MemWrite is committed on the posedge where it is high.
// MemRead is a same-cycle combinational read. A read-clear flag drops on that
// same posedge, unless a hardware set event occurs in that cycle.
module uart_mmio_periph #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq,
  output logic [2:0]  tx_state_dbg_o,
  output logic [2:0]  rx_state_dbg_o
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [31:0] TXD_ADDR = BASE_ADDR;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  tx_state_t tx_state_q, tx_state_d;
  rx_state_t rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic          tx_q, tx_d;
  logic [7:0]    txd_q, rxd_q, rx_shift_q, rx_shift_d;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          tx_ie_q, rx_ie_q, tx_done_q, rx_ready_q, rx_overrun_q, parity_err_q;
  logic          irq_q;
  logic          tx_done_set, rx_store, perr_set;
`ifdef UART_PARITY_EN
  logic          rx_par_q, rx_par_d;
`endif

  logic sel_txd, sel_rxd, sel_con;
  logic txd_wr, con_wr, con_rd, rxd_rd, tx_busy;
  logic unused_bits;

  assign sel_txd = (addr[31:2] == TXD_ADDR[31:2]);
  assign sel_rxd = (addr[31:2] == RXD_ADDR[31:2]);
  assign sel_con = (addr[31:2] == CON_ADDR[31:2]);
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign txd_wr  = MemWrite && sel_txd && !tx_busy;
  assign con_wr  = MemWrite && sel_con;
  assign con_rd  = MemRead && sel_con;
  assign rxd_rd  = MemRead && sel_rxd;
  assign unused_bits = ^{wdata[31:8], addr[1:0]};

  assign tx             = tx_q;
  assign irq            = irq_q;
  assign tx_state_dbg_o = tx_state_q;
  assign rx_state_dbg_o = rx_state_q;

  // Register read mux; zero unless a mapped register is being read.
  always_comb begin
    rdata = 32'd0;
    if (MemRead) begin
      if (sel_txd)      rdata = {24'd0, txd_q};
      else if (sel_rxd) rdata = {24'd0, rxd_q};
      else if (sel_con) rdata = {25'd0, parity_err_q, rx_overrun_q, tx_busy,
                                 rx_ready_q, tx_done_q, rx_ie_q, tx_ie_q};
    end
  end

  // TX next state; the line value is derived from the next state so tx is a clean flop.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_done_set = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (txd_wr) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      TX_DATA: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_bit_d = 3'd0;
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
`else
            tx_state_d = TX_STOP;
`endif
          end else tx_bit_d = tx_bit_q + 3'd1;
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_state_d = TX_STOP;
          tx_cnt_d   = '0;
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
`endif
      TX_STOP: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_state_d  = TX_IDLE;
          tx_cnt_d    = '0;
          tx_done_set = 1'b1;
        end else tx_cnt_d = tx_cnt_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = txd_q[tx_bit_d];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_d = ^txd_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // RX next state: half-bit start check, then mid-bit sampling every DIV clocks.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_store   = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_bit_d = 3'd0;
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s2_q;
          rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
`endif
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_store   = rx_s2_q;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  assign perr_set = rx_store && (rx_par_q != ^rx_shift_q);
`else
  assign perr_set = 1'b0;
`endif

  // FSM state, counters, line flop and the rx synchroniser.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      rx_bit_q   <= 3'd0;
      tx_q       <= 1'b1;
      rx_shift_q <= 8'd0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
`ifdef UART_PARITY_EN
      rx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      rx_bit_q   <= rx_bit_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
`endif
    end
  end

  // Software-visible registers and flags; hardware set events beat clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txd_q        <= 8'd0;
      rxd_q        <= 8'd0;
      tx_ie_q      <= 1'b0;
      rx_ie_q      <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_ready_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      parity_err_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (txd_wr) txd_q <= wdata[7:0];
      if (rx_store) rxd_q <= rx_shift_q;
      if (con_wr) begin
        tx_ie_q <= wdata[0];
        rx_ie_q <= wdata[1];
      end
      tx_done_q    <= tx_done_set || (tx_done_q && !(con_rd || (con_wr && !wdata[2])));
      rx_ready_q   <= rx_store || (rx_ready_q && !rxd_rd);
      rx_overrun_q <= (rx_store && rx_ready_q) || (rx_overrun_q && !rxd_rd);
      parity_err_q <= perr_set || (parity_err_q && !rxd_rd);
      irq_q        <= (tx_ie_q && tx_done_q) || (rx_ie_q && rx_ready_q);
    end
  end

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Bench for uart_mmio_periph (DIV = 16). Build with +define+UART_PARITY_EN for the 8E1 variant.
// A transmit model holds the expected line level for every cycle of a frame.
// A receive model holds the bytes delivered since RXD was last read.
// A single negedge process compares tx every cycle and services directed checks.
module tb_uart_mmio_periph;
  localparam int unsigned CLK_HZ = 160;
  localparam int unsigned BAUD   = 10;
  localparam int unsigned DIV    = 16;
  localparam logic [31:0] TXD_A  = 32'h4000_0018;
  localparam logic [31:0] RXD_A  = 32'h4000_001C;
  localparam logic [31:0] CON_A  = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] rdata;
  logic        tx, irq;
  logic [2:0]  unused_tx_dbg, unused_rx_dbg;

  always #5 clk = ~clk;

  uart_mmio_periph #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BASE_ADDR(TXD_A)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .MemRead(MemRead),
    .MemWrite(MemWrite), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq),
    .tx_state_dbg_o(unused_tx_dbg), .rx_state_dbg_o(unused_rx_dbg)
  );

  // Model state.
  logic [0:0] exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic       m_tx_ie = 1'b0, m_rx_ie = 1'b0, m_tx_done = 1'b0, m_perr = 1'b0;
  logic [7:0] m_rxd = 8'd0;
`ifdef UART_PARITY_EN
  logic       rx_par_flip = 1'b0;
`endif

  int checks = 0, fails = 0;
  int req_seq = 0, done_seq = 0, req_kind = 0;
  string req_name = "";
  logic [31:0] req_exp = 32'd0;
  logic started = 1'b0;

  function automatic logic [31:0] exp_con();
    logic [31:0] v;
    v = 32'd0;
    v[0] = m_tx_ie;
    v[1] = m_rx_ie;
    v[2] = m_tx_done;
    v[3] = (rx_exp_q.size() != 0);
    v[4] = (exp_q.size() != 0);
    v[5] = (rx_exp_q.size() > 1);
    v[6] = m_perr;
    return v;
  endfunction

  // Transmit/control model: one queue entry per clock of the frame being sent.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_tx_ie = 1'b0;
      m_rx_ie = 1'b0;
      m_tx_done = 1'b0;
    end else begin
      if (MemRead && addr == CON_A) m_tx_done = 1'b0;
      if (MemWrite && addr == CON_A) begin
        m_tx_ie = wdata[0];
        m_rx_ie = wdata[1];
        if (!wdata[2]) m_tx_done = 1'b0;
      end
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) m_tx_done = 1'b1;
      end else if (MemWrite && addr == TXD_A) begin
        for (int k = 0; k < DIV; k++) exp_q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
          for (int k = 0; k < DIV; k++) exp_q.push_back(wdata[b]);
`ifdef UART_PARITY_EN
        for (int k = 0; k < DIV; k++) exp_q.push_back(^wdata[7:0]);
`endif
        for (int k = 0; k < DIV; k++) exp_q.push_back(1'b1);
      end
    end
  end

  // Compare process: tx against the model every cycle, plus any pending directed check.
  always @(negedge clk) begin
    logic        exp_tx;
    logic [31:0] act;
    if (started) begin
      exp_tx = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
      checks++;
      if (tx !== exp_tx) begin
        fails++;
        if (fails < 20) $display("FAIL tx_line t=%0t actual=%b expected=%b", $time, tx, exp_tx);
      end
    end
    if (req_seq != done_seq) begin
      act = (req_kind == 0) ? rdata : (req_kind == 1) ? {31'd0, tx} : {31'd0, irq};
      checks++;
      if (act !== req_exp) begin
        fails++;
        $display("FAIL %s t=%0t actual=%h expected=%h", req_name, $time, act, req_exp);
      end
      done_seq = req_seq;
    end
  end

  // kind: 0 rdata, 1 tx, 2 irq; checked at the next negedge.
  task automatic expect_now(input int kind, input string name, input logic [31:0] exp);
    req_kind = kind;
    req_name = name;
    req_exp  = exp;
    req_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, input string name, input logic [31:0] exp);
    @(posedge clk); #1;
    addr = a; MemRead = 1'b1;
    expect_now(0, name, exp);
    @(posedge clk); #1;
    MemRead = 1'b0; addr = 32'd0;
  endtask

  task automatic bus_read_con(input string name);
    @(posedge clk); #1;
    addr = CON_A; MemRead = 1'b1;
    expect_now(0, name, exp_con());
    @(posedge clk); #1;
    MemRead = 1'b0; addr = 32'd0;
  endtask

  task automatic read_rxd(input string name, input logic [7:0] exp);
    bus_read(RXD_A, name, {24'd0, exp});
    rx_exp_q.delete();
    m_perr = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_v);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #1 rx = b[i];
    end
`ifdef UART_PARITY_EN
    repeat (DIV) @(posedge clk);
    #1 rx = (^b) ^ rx_par_flip;
`endif
    repeat (DIV) @(posedge clk);
    #1 rx = stop_v;
    repeat (DIV) @(posedge clk);
    #1 rx = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
    if (stop_v) begin
      rx_exp_q.push_back(b);
      m_rxd = b;
    end
  endtask

  initial begin
    // Reset.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1'b1;
    bus_read(CON_A, "rst_con", 32'd0);
    bus_read(RXD_A, "rst_rxd", 32'd0);
    expect_now(2, "rst_irq", 32'd0);
    bus_read(TXD_A + 32'd12, "unmapped_rd", 32'd0);

    // TX 0xA5 with a write of 0x3C landing mid-frame.
    bus_write(TXD_A, 32'hA5);
    idle(7);
    expect_now(1, "tx_start_bit", 32'd0);
    idle(15);
    expect_now(1, "tx_bit0", 32'd1);
    idle(15);
    expect_now(1, "tx_bit1", 32'd0);
    idle(15);
    expect_now(1, "tx_bit2", 32'd1);
    bus_write(TXD_A, 32'h3C);
    bus_read(TXD_A, "txd_keeps_a5", 32'hA5);
    bus_read(CON_A, "con_busy", 32'h10);
    idle(120);
    bus_read(CON_A, "con_tx_done", 32'h04);
    bus_read_con("con_done_rc");
    expect_now(2, "irq_tx_ie_off", 32'd0);

    // tx_ie enabled: irq follows tx_done; writing 1 to bit2 keeps it.
    bus_write(CON_A, 32'h1);
    bus_write(TXD_A, 32'h0F);
    idle(170);
    expect_now(2, "irq_tx_done", 32'd1);
    bus_write(CON_A, 32'h5);
    bus_read_con("con_w1_keeps_done");
    idle(1);
    expect_now(2, "irq_after_rc", 32'd0);

    // Write-0-to-clear of tx_done.
    bus_write(TXD_A, 32'h81);
    idle(170);
    bus_write(CON_A, 32'h0);
    bus_read(CON_A, "con_w0c", 32'd0);

    // RX frame 0x5A with rx_ie.
    bus_write(CON_A, 32'h2);
    send_rx(8'h5A, 1'b1);
    expect_now(2, "irq_rx_ready", 32'd1);
    @(posedge clk); #1;
    addr = CON_A; MemRead = 1'b0;
    expect_now(0, "rd_strobe_off", 32'd0);
    addr = 32'd0;
    bus_read(CON_A, "con_rx_ready", 32'h0A);
    read_rxd("rxd_5a", 8'h5A);
    bus_read_con("con_rx_cleared");
    expect_now(2, "irq_rx_cleared", 32'd0);

    // Two frames unread: overrun.
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read_con("con_overrun");
    bus_read(CON_A, "con_overrun_lit", 32'h2A);
    read_rxd("rxd_22", 8'h22);
    bus_read_con("con_ovr_cleared");

    // 8-clock glitch and a bad stop bit produce no frame.
    @(posedge clk); #1 rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 rx = 1'b1;
    idle(40);
    bus_read_con("con_glitch");
    send_rx(8'h77, 1'b0);
    bus_read_con("con_bad_stop");
    read_rxd("rxd_unchanged", m_rxd);
    send_rx(8'hC3, 1'b1);
    read_rxd("rxd_c3", m_rxd);

    // Reset in the middle of TX bit 3.
    bus_write(TXD_A, 32'h96);
    idle(68);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rx_exp_q.delete();
    m_rxd = 8'd0;
    m_perr = 1'b0;
    expect_now(1, "tx_after_rst", 32'd1);
    bus_read(CON_A, "con_after_rst", 32'd0);
    bus_read(RXD_A, "rxd_after_rst", 32'd0);
    bus_write(TXD_A, 32'h3C);
    idle(170);
    bus_read(TXD_A, "txd_3c", 32'h3C);
    bus_read_con("con_post_rst_tx");

`ifdef UART_PARITY_EN
    // Even parity: 0x07 has three ones so the parity bit is 1.
    bus_write(TXD_A, 32'h07);
    idle(150);
    expect_now(1, "tx_parity_bit", 32'd1);
    idle(20);
    rx_par_flip = 1'b1;
    send_rx(8'h07, 1'b1);
    m_perr = 1'b1;
    rx_par_flip = 1'b0;
    bus_read_con("con_parity_err");
    read_rxd("rxd_07_par", 8'h07);
    bus_read_con("con_parity_cleared");
`endif

    idle(20);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
